// File: rtl/t03_hit_resolver.sv
`default_nettype none
// t03_hit_resolver: resolves punches between two players and runs the READY/FIGHT/KO round flow.
// Optional macro T03_CHIP_DAMAGE_EN: a blocked punch deals CHIP_DAMAGE instead of nothing.
module t03_hit_resolver #(
  parameter logic [6:0] MAX_HEALTH    = 7'd100,
  parameter logic [6:0] DAMAGE        = 7'd10,
  parameter logic [6:0] CHIP_DAMAGE   = 7'd2,
  parameter logic [3:0] INVULN_FRAMES = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       finished,
  input  logic       start,
  input  logic [1:0] p1_state,
  input  logic [1:0] p2_state,
  input  logic       p1_resting,
  input  logic       p2_resting,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_FIGHT = 2'd1;
  localparam logic [1:0] ST_KO    = 2'd2;

`ifdef T03_CHIP_DAMAGE_EN
  localparam logic [6:0] BLOCK_DMG = CHIP_DAMAGE;
`else
  // Blocked punches are harmless in this build.
  localparam logic [6:0] BLOCK_DMG = CHIP_DAMAGE & 7'd0;
`endif

  logic [1:0] state_q, state_d;
  logic       start_pending_q;
  logic       prev_atk1_q, prev_atk2_q;
  logic [6:0] hp1_q, hp2_q;
  logic [3:0] inv1_q, inv2_q;
  logic       hit1_q, hit2_q;
  logic [1:0] winner_q;

  logic       w_atk1, w_atk2, w_grd1, w_grd2, w_land1, w_land2;
  logic       w_pending, w_fight, w_ko, w_enter_ready, w_consume;
  logic [6:0] w_dmg1, w_dmg2, w_hp1_new, w_hp2_new;
  logic [3:0] w_inv1_dec, w_inv2_dec;

  assign w_atk1  = (p1_state == 2'd1) && !p1_resting;
  assign w_atk2  = (p2_state == 2'd1) && !p2_resting;
  assign w_grd1  = (p1_state == 2'd2) && !p1_resting;
  assign w_grd2  = (p2_state == 2'd2) && !p2_resting;
  assign w_land1 = w_atk1 && !prev_atk1_q;
  assign w_land2 = w_atk2 && !prev_atk2_q;

  assign w_pending = start_pending_q || start;
  assign w_fight   = (state_q == ST_FIGHT);

  // Damage is decided from pre-tick invulnerability and guard of the defender.
  assign w_dmg1 = (w_fight && w_land2 && inv1_q == 4'd0) ? (w_grd1 ? BLOCK_DMG : DAMAGE) : 7'd0;
  assign w_dmg2 = (w_fight && w_land1 && inv2_q == 4'd0) ? (w_grd2 ? BLOCK_DMG : DAMAGE) : 7'd0;

  assign w_hp1_new = (hp1_q > w_dmg1) ? hp1_q - w_dmg1 : 7'd0;
  assign w_hp2_new = (hp2_q > w_dmg2) ? hp2_q - w_dmg2 : 7'd0;
  assign w_ko      = w_fight && (w_hp1_new == 7'd0 || w_hp2_new == 7'd0);

  assign w_inv1_dec = (inv1_q != 4'd0) ? inv1_q - 4'd1 : 4'd0;
  assign w_inv2_dec = (inv2_q != 4'd0) ? inv2_q - 4'd1 : 4'd0;

  assign w_enter_ready = finished && ((state_q == ST_KO && w_pending) || state_q == 2'd3);
  assign w_consume     = finished && w_pending && (state_q == ST_READY || state_q == ST_KO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_READY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (finished) begin
      case (state_q)
        ST_READY: if (w_pending) state_d = ST_FIGHT;
        ST_FIGHT: if (w_ko)      state_d = ST_KO;
        ST_KO:    if (w_pending) state_d = ST_READY;
        default:                 state_d = ST_READY;
      endcase
    end
  end

  always_comb begin
    game_over = (state_q == ST_KO);
    p1_health = hp1_q;
    p2_health = hp2_q;
    p1_hit    = hit1_q;
    p2_hit    = hit2_q;
    winner    = winner_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_pending_q <= 1'b0;
      prev_atk1_q     <= 1'b0;
      prev_atk2_q     <= 1'b0;
      hp1_q           <= MAX_HEALTH;
      hp2_q           <= MAX_HEALTH;
      inv1_q          <= 4'd0;
      inv2_q          <= 4'd0;
      hit1_q          <= 1'b0;
      hit2_q          <= 1'b0;
      winner_q        <= 2'b00;
    end else begin
      hit1_q          <= 1'b0;
      hit2_q          <= 1'b0;
      start_pending_q <= w_pending && !w_consume;
      if (finished) begin
        prev_atk1_q <= w_atk1;
        prev_atk2_q <= w_atk2;
        if (w_enter_ready) begin
          hp1_q    <= MAX_HEALTH;
          hp2_q    <= MAX_HEALTH;
          inv1_q   <= 4'd0;
          inv2_q   <= 4'd0;
          winner_q <= 2'b00;
        end else begin
          // Outside FIGHT the damage terms are zero, so healths hold.
          hp1_q  <= w_hp1_new;
          hp2_q  <= w_hp2_new;
          inv1_q <= (w_dmg1 != 7'd0) ? INVULN_FRAMES : w_inv1_dec;
          inv2_q <= (w_dmg2 != 7'd0) ? INVULN_FRAMES : w_inv2_dec;
          hit1_q <= (w_dmg1 != 7'd0);
          hit2_q <= (w_dmg2 != 7'd0);
          if (w_ko) winner_q <= {w_hp1_new == 7'd0, w_hp2_new == 7'd0};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_t03_hit_resolver.sv
`default_nettype none
// Testbench for t03_hit_resolver: directed round scenarios plus randomized play against a behavioural model.
module tb_t03_hit_resolver;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] A = 2'd1;
  localparam logic [1:0] B = 2'd2;
  localparam int MAXH = 100;
  localparam int DMG  = 10;
  localparam int INV  = 8;
`ifdef T03_CHIP_DAMAGE_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, finished, start;
  logic [1:0] p1_state, p2_state;
  logic       p1_resting, p2_resting;
  logic [6:0] p1_health, p2_health, s_p1_health, s_p2_health;
  logic       p1_hit, p2_hit, game_over, s_p1_hit, s_p2_hit, s_game_over;
  logic [1:0] winner, s_winner;

  t03_hit_resolver u_dut (
    .clk(clk), .rst(rst), .finished(finished), .start(start),
    .p1_state(p1_state), .p2_state(p2_state),
    .p1_resting(p1_resting), .p2_resting(p2_resting),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .game_over(game_over), .winner(winner)
  );

  // Second instance starting at 95 so a 10-point punch must saturate at 5 -> 0.
  t03_hit_resolver #(.MAX_HEALTH(7'd95)) u_sat (
    .clk(clk), .rst(rst), .finished(finished), .start(start),
    .p1_state(p1_state), .p2_state(p2_state),
    .p1_resting(p1_resting), .p2_resting(p2_resting),
    .p1_health(s_p1_health), .p2_health(s_p2_health),
    .p1_hit(s_p1_hit), .p2_hit(s_p2_hit),
    .game_over(s_game_over), .winner(s_winner)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: phase 0 ready, 1 fight, 2 knocked out.
  int m_hp1, m_hp2, m_inv1, m_inv2, m_phase, m_win;
  bit m_prev1, m_prev2, m_pend, m_hit1, m_hit2;

  task automatic model_reset();
    m_hp1 = MAXH; m_hp2 = MAXH; m_inv1 = 0; m_inv2 = 0;
    m_phase = 0; m_win = 0; m_prev1 = 0; m_prev2 = 0;
    m_pend = 0; m_hit1 = 0; m_hit2 = 0;
  endtask

  task automatic model_edge();
    bit a1, a2, g1, g2, l1, l2, pn;
    int d1, d2;
    m_hit1 = 0; m_hit2 = 0;
    pn = m_pend || start;
    if (!finished) begin
      m_pend = pn;
      return;
    end
    a1 = (p1_state == 2'd1) && !p1_resting;
    a2 = (p2_state == 2'd1) && !p2_resting;
    g1 = (p1_state == 2'd2) && !p1_resting;
    g2 = (p2_state == 2'd2) && !p2_resting;
    l1 = a1 && !m_prev1;
    l2 = a2 && !m_prev2;
    m_prev1 = a1; m_prev2 = a2;
    d1 = 0; d2 = 0;
    if (m_phase == 1) begin
      if (l2 && m_inv1 == 0) d1 = g1 ? BLK : DMG;
      if (l1 && m_inv2 == 0) d2 = g2 ? BLK : DMG;
    end
    if (m_inv1 > 0) m_inv1--;
    if (m_inv2 > 0) m_inv2--;
    case (m_phase)
      0: if (pn) begin m_phase = 1; pn = 0; end
      1: begin
        if (d1 > 0) begin m_inv1 = INV; m_hit1 = 1; end
        if (d2 > 0) begin m_inv2 = INV; m_hit2 = 1; end
        m_hp1 = (m_hp1 > d1) ? m_hp1 - d1 : 0;
        m_hp2 = (m_hp2 > d2) ? m_hp2 - d2 : 0;
        if (m_hp1 == 0 || m_hp2 == 0) begin
          m_phase = 2;
          m_win = (m_hp1 == 0 ? 2 : 0) + (m_hp2 == 0 ? 1 : 0);
        end
      end
      default: if (pn) begin
        m_phase = 0; m_hp1 = MAXH; m_hp2 = MAXH;
        m_inv1 = 0; m_inv2 = 0; m_win = 0; pn = 0;
      end
    endcase
    m_pend = pn;
  endtask

  function automatic logic [18:0] model_vec();
    return {7'(m_hp1), 7'(m_hp2), m_hit1, m_hit2, (m_phase == 2), 2'(m_win)};
  endfunction

  task automatic step(input bit fin, input bit st, input logic [1:0] s1, input bit r1,
                      input logic [1:0] s2, input bit r2);
    finished = fin; start = st;
    p1_state = s1; p1_resting = r1; p2_state = s2; p2_resting = r2;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic start_round();
    pulse_reset();
    step(1'b0, 1'b1, I, 1'b0, I, 1'b0);
    step(1'b1, 1'b0, I, 1'b0, I, 1'b0);
  endtask

  task automatic test_reset();
    finished = 1'b0; start = 1'b0;
    p1_state = I; p2_state = I; p1_resting = 1'b0; p2_resting = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    n_checks++; if (p1_health !== 7'd100) $display("FAIL reset_p1_health: got %0d want 100", p1_health); else n_pass++;
    n_checks++; if (p2_health !== 7'd100) $display("FAIL reset_p2_health: got %0d want 100", p2_health); else n_pass++;
    n_checks++; if ({p1_hit, p2_hit} !== 2'b00) $display("FAIL reset_hits: got %b want 00", {p1_hit, p2_hit}); else n_pass++;
    n_checks++; if (game_over !== 1'b0) $display("FAIL reset_game_over: got %b want 0", game_over); else n_pass++;
    n_checks++; if (winner !== 2'b00) $display("FAIL reset_winner: got %b want 00", winner); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_start();
    step(1'b0, 1'b1, I, 1'b0, I, 1'b0);
    step(1'b1, 1'b0, I, 1'b0, I, 1'b0);
    n_checks++; if ({p1_health, p2_health} !== {7'd100, 7'd100})
      $display("FAIL start_healths: got %0d/%0d want 100/100", p1_health, p2_health); else n_pass++;
    n_checks++; if ({game_over, winner} !== 3'b000)
      $display("FAIL start_status: got go=%b win=%b want go=0 win=00", game_over, winner); else n_pass++;
  endtask

  task automatic test_single_punch();
    step(1'b1, 1'b0, A, 1'b0, I, 1'b0);
    n_checks++; if (p2_health !== 7'd90) $display("FAIL punch_p2_health: got %0d want 90", p2_health); else n_pass++;
    n_checks++; if ({p1_hit, p2_hit} !== 2'b01) $display("FAIL punch_hit_pulse: got %b want 01", {p1_hit, p2_hit}); else n_pass++;
    n_checks++; if (p1_health !== 7'd100) $display("FAIL punch_p1_health: got %0d want 100", p1_health); else n_pass++;
    step(1'b0, 1'b0, A, 1'b0, I, 1'b0);
    n_checks++; if (p2_hit !== 1'b0) $display("FAIL punch_hit_clear: got %b want 0", p2_hit); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, A, 1'b0, I, 1'b0);
      n_checks++; if ({p2_health, p2_hit} !== {7'd90, 1'b0})
        $display("FAIL held_attack_tick%0d: got hp=%0d hit=%b want hp=90 hit=0", k, p2_health, p2_hit); else n_pass++;
    end
  endtask

  task automatic test_invuln();
    start_round();
    for (int k = 0; k <= 9; k++) begin
      step(1'b1, 1'b0, (k == 0 || k == 3 || k == 9) ? A : I, 1'b0, I, 1'b0);
      if (k == 0) begin
        n_checks++; if (p2_health !== 7'd90) $display("FAIL invuln_first: got %0d want 90", p2_health); else n_pass++;
      end
      if (k == 3) begin
        n_checks++; if ({p2_health, p2_hit} !== {7'd90, 1'b0})
          $display("FAIL invuln_blocked: got hp=%0d hit=%b want hp=90 hit=0", p2_health, p2_hit); else n_pass++;
      end
      if (k == 9) begin
        n_checks++; if ({p2_health, p2_hit} !== {7'd80, 1'b1})
          $display("FAIL invuln_expired: got hp=%0d hit=%b want hp=80 hit=1", p2_health, p2_hit); else n_pass++;
      end
    end
  endtask

  task automatic test_guard();
    start_round();
    step(1'b1, 1'b0, A, 1'b0, B, 1'b0);
    n_checks++; if (p2_health !== 7'(MAXH - BLK))
      $display("FAIL guard_health: got %0d want %0d", p2_health, MAXH - BLK); else n_pass++;
    n_checks++; if (p2_hit !== (BLK != 0))
      $display("FAIL guard_hit: got %b want %b", p2_hit, (BLK != 0)); else n_pass++;
  endtask

  task automatic test_double_ko();
    start_round();
    for (int k = 0; k <= 81; k++) begin
      step(1'b1, 1'b0, (k % 9 == 0) ? A : I, 1'b0, (k % 9 == 0) ? A : I, 1'b0);
      if (k == 72) begin
        n_checks++; if ({p1_health, p2_health} !== {7'd10, 7'd10})
          $display("FAIL double_pre_ko: got %0d/%0d want 10/10", p1_health, p2_health); else n_pass++;
      end
    end
    n_checks++; if ({p1_health, p2_health, game_over, winner} !== {7'd0, 7'd0, 1'b1, 2'b11})
      $display("FAIL double_ko: got %0d/%0d go=%b win=%b want 0/0 go=1 win=11",
               p1_health, p2_health, game_over, winner); else n_pass++;
    step(1'b1, 1'b0, I, 1'b0, I, 1'b0);
    step(1'b1, 1'b0, A, 1'b0, A, 1'b0);
    n_checks++; if ({p1_hit, p2_hit, game_over} !== 3'b001)
      $display("FAIL ko_frozen: got hits=%b go=%b want hits=00 go=1", {p1_hit, p2_hit}, game_over); else n_pass++;
    step(1'b0, 1'b1, I, 1'b0, I, 1'b0);
    step(1'b1, 1'b0, I, 1'b0, I, 1'b0);
    n_checks++; if ({p1_health, p2_health, game_over, winner} !== {7'd100, 7'd100, 1'b0, 2'b00})
      $display("FAIL ko_restart: got %0d/%0d go=%b win=%b want 100/100 go=0 win=00",
               p1_health, p2_health, game_over, winner); else n_pass++;
  endtask

  task automatic test_p1_wins();
    start_round();
    for (int k = 0; k <= 81; k++) step(1'b1, 1'b0, (k % 9 == 0) ? A : I, 1'b0, I, 1'b0);
    n_checks++; if ({p1_health, p2_health, game_over, winner} !== {7'd100, 7'd0, 1'b1, 2'b01})
      $display("FAIL p1_wins: got %0d/%0d go=%b win=%b want 100/0 go=1 win=01",
               p1_health, p2_health, game_over, winner); else n_pass++;
    n_checks++; if ({s_p2_health, s_winner, s_game_over} !== {7'd0, 2'b01, 1'b1})
      $display("FAIL saturate_to_zero: got hp=%0d win=%b go=%b want hp=0 win=01 go=1",
               s_p2_health, s_winner, s_game_over); else n_pass++;
  endtask

  task automatic test_reset_mid_fight();
    start_round();
    step(1'b0, 1'b1, I, 1'b0, I, 1'b0);
    step(1'b1, 1'b0, A, 1'b0, I, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if ({p1_health, p2_health, p1_hit, p2_hit, game_over, winner} !== {7'd100, 7'd100, 5'b00000})
      $display("FAIL mid_reset: got %0d/%0d hits=%b go=%b win=%b want 100/100 hits=00 go=0 win=00",
               p1_health, p2_health, {p1_hit, p2_hit}, game_over, winner); else n_pass++;
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, A, 1'b0, I, 1'b0);
    n_checks++; if (p2_hit !== 1'b0) $display("FAIL mid_reset_no_pulse: got %b want 0", p2_hit); else n_pass++;
    step(1'b1, 1'b0, I, 1'b0, I, 1'b0);
    step(1'b1, 1'b0, A, 1'b0, I, 1'b0);
    n_checks++; if ({p2_health, p2_hit} !== {7'd100, 1'b0})
      $display("FAIL mid_reset_pending_cleared: got hp=%0d hit=%b want hp=100 hit=0", p2_health, p2_hit); else n_pass++;
  endtask

  task automatic test_random();
    logic [18:0] obs;
    pulse_reset();
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0,
           2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      obs = {p1_health, p2_health, p1_hit, p2_hit, game_over, winner};
      n_checks++; if (obs !== model_vec())
        $display("FAIL random_cycle%0d: got %h want %h", k, obs, model_vec()); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_single_punch();
    test_invuln();
    test_guard();
    test_double_ko();
    test_p1_wins();
    test_reset_mid_fight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/t03_hit_resolver.md
T03_HIT_RESOLVER -- requirements
Module: t03_hit_resolver

Interface
REQ-001 Parameter MAX_HEALTH, 7'd100, health loaded into each player at round start.
REQ-002 Parameter DAMAGE, 7'd10, health removed by an unblocked punch.
REQ-003 Parameter CHIP_DAMAGE, 7'd2, health removed by a blocked punch (used only under T03_CHIP_DAMAGE_EN).
REQ-004 Parameter INVULN_FRAMES, 4'd8, frame ticks of invulnerability after taking damage.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 finished  input  1  frame tick; all game-state updates occur only on clk edges where finished=1.
REQ-008 start  input  1  round start/restart request, any-cycle pulse.
REQ-009 p1_state, p2_state  input  2 each  player FSM state: 0 INIT, 1 PUNCHING, 2 BLOCKING, 3 invalid.
REQ-010 p1_resting, p2_resting  input  1 each  player resting flag from the player FSM.
REQ-011 p1_health, p2_health  output  7 each  current health.
REQ-012 p1_hit, p2_hit  output  1 each  one-clk pulse: that player took damage.
REQ-013 game_over  output  1  high while in KO.
REQ-014 winner  output  2  00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-015 Attack active for player n = (pn_state==1 && !pn_resting); guard active = (pn_state==2 && !pn_resting); state 3 counts as neither.
REQ-016 Per player, prev_attack register updated on every finished tick in every FSM state; a punch lands only on a tick where attack=1 and prev_attack=0.
REQ-017 start latched into start_pending on any clk where start=1; cleared on the finished tick that consumes it.
REQ-018 FSM states READY, FIGHT, KO; READY->FIGHT on finished tick with start_pending; KO->READY on finished tick with start_pending; FIGHT ignores start_pending (stays latched, not cleared).
REQ-019 Entering READY: both healths=MAX_HEALTH, invuln counters=0, winner=00.
REQ-020 In FIGHT, landed punch against defender with invuln counter=0: damage=DAMAGE if defender guard inactive, else blocked damage (REQ-031/032).
REQ-021 Landed punch against defender with invuln counter!=0: no damage, no hit pulse.
REQ-022 Health update saturates: health <= (health > dmg) ? health-dmg : 0; no wrap below 0.
REQ-023 Damage>0 applied: defender invuln counter loads INVULN_FRAMES, defender hit pulse asserted exactly one clk after the tick, deasserted next clk regardless of finished.
REQ-024 Invuln counters decrement by 1 per finished tick when nonzero, saturate at 0; a reload on the same tick wins over decrement.
REQ-025 Simultaneous landed punches on one tick: both resolved independently from pre-tick health/guard.
REQ-026 After the tick's damage, any health==0 -> KO same tick; winner 01 if only P2 at 0, 10 if only P1 at 0, 11 if both.
REQ-027 In READY and KO no damage, no hit pulses, healths frozen.
REQ-028 Hit pulse clears even if finished deasserts mid-round; no update when finished=0.

Reset
REQ-029 rst forces: READY, healths=MAX_HEALTH, invuln=0, prev_attack=0, start_pending=0, p1_hit=p2_hit=0, game_over=0, winner=00.
REQ-030 rst asserted mid-FIGHT aborts the round immediately; no pulse is emitted after release until a new landed punch.

Configuration
REQ-031 Macro T03_CHIP_DAMAGE_EN defined: blocked landed punch deals CHIP_DAMAGE (with invuln reload and hit pulse per REQ-023).
REQ-032 Macro undefined: blocked landed punch deals 0, no invuln reload, no hit pulse; CHIP_DAMAGE unused.

Verification
REQ-033 Reset, start pulse, 1 tick -> FIGHT, healths 100/100, winner 00, game_over 0.
REQ-034 P1 attack rises, P2 INIT -> p2_health 90, p2_hit one clk, P1 attack held 5 more ticks -> no further damage.
REQ-035 P1 punches again at tick 3 after hit (invuln 8) -> no damage; punch at tick 9 -> p2_health 80.
REQ-036 P2 guard active, P1 punches -> p2_health 98 with T03_CHIP_DAMAGE_EN, 100 without.
REQ-037 Both at 10, simultaneous landed punches -> both 0, KO, winner 11, game_over 1; start -> READY, 100/100.
REQ-038 p2_health 5, P1 lands -> p2_health 0 (saturated), winner 01; rst asserted mid-FIGHT -> all REQ-029 values.
